// File: rtl/rca_serial_subtractor.sv
// Bit-serial ripple-borrow subtractor: {bout, d} = a - b - bin, one bit per clock, LSB first.
// A single full-subtractor cell is reused for every bit; the handshake is valid/ready on both sides.
module rca_serial_subtractor #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         bin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] d,
  output logic         bout
);

  localparam int CW = (W > 2) ? $clog2(W) : 1;
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e        state_q, state_d;
  logic [W-1:0]  a_sr_q, a_sr_d;
  logic [W-1:0]  b_sr_q, b_sr_d;
  logic [W-1:0]  d_q, d_d;
  logic          br_q, br_d;
  logic          bout_q, bout_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          diff;
  logic          br_next;

  // One full-subtractor cell, fed from the LSBs of the operand shift registers.
  assign diff    = a_sr_q[0] ^ b_sr_q[0] ^ br_q;
  assign br_next = (~a_sr_q[0] & b_sr_q[0]) | (~(a_sr_q[0] ^ b_sr_q[0]) & br_q);

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign d         = d_q;
  assign bout      = bout_q;

  always_comb begin
    // NOTE: every next-state signal gets a hold default first so no path through the case infers a latch.
    state_d = state_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    d_d     = d_q;
    br_d    = br_q;
    bout_d  = bout_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_sr_d  = a;
          b_sr_d  = b;
          br_d    = bin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        // The minuend register doubles as the result register: consumed bits leave at
        // the LSB while difference bits enter at the MSB.
        a_sr_d = {diff, a_sr_q[W-1:1]};
        b_sr_d = b_sr_q >> 1;
        br_d   = br_next;
        if (cnt_q == LAST) begin
          d_d     = {diff, a_sr_q[W-1:1]};
          bout_d  = br_next;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only; every flop here is control or
  // datapath state (no memory array), so all of them take the asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      d_q     <= '0;
      br_q    <= 1'b0;
      bout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      d_q     <= d_d;
      br_q    <= br_d;
      bout_q  <= bout_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_rca_serial_subtractor.sv
// Scoreboard bench for rca_serial_subtractor at W=8 (directed + random) and W=16 (random).
// Expected results come from plain (W+1)-bit arithmetic on the accepted operands.
module tb_rca_serial_subtractor;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       iv8, ir8, ov8, or8, bin8, bo8;
  logic [7:0] a8, b8, d8;
  logic        iv16, ir16, ov16, or16, bin16, bo16;
  logic [15:0] a16, b16, d16;

  rca_serial_subtractor #(.W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8), .bin(bin8),
    .out_valid(ov8), .out_ready(or8), .d(d8), .bout(bo8)
  );

  rca_serial_subtractor #(.W(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16), .bin(bin16),
    .out_valid(ov16), .out_ready(or16), .d(d16), .bout(bo16)
  );

  int checks = 0;
  int errors = 0;
  logic [8:0]  q8[$];
  logic [16:0] q16[$];
  int n_acc8 = 0, n_res8 = 0, n_acc16 = 0, n_res16 = 0;
  bit done8 = 0, done16 = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [8:0] ref8(input logic [7:0] x, input logic [7:0] y, input logic c);
    return {1'b0, x} - {1'b0, y} - {8'd0, c};
  endfunction

  function automatic logic [16:0] ref16(input logic [15:0] x, input logic [15:0] y, input logic c);
    return {1'b0, x} - {1'b0, y} - {16'd0, c};
  endfunction

  // Monitor/scoreboard: acceptances push a model result, completed output handshakes pop and compare.
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_acc8  = n_acc8 - q8.size();
      n_acc16 = n_acc16 - q16.size();
      q8.delete();
      q16.delete();
    end else begin
      if (iv8 && ir8) begin
        q8.push_back(ref8(a8, b8, bin8));
        n_acc8++;
      end
      if (ov8 && or8) begin
        if (q8.size() == 0) check("res8_unexpected", 32'(ov8), 32'd0);
        else begin
          check("res8", 32'({bo8, d8}), 32'(q8.pop_front()));
          n_res8++;
        end
      end
      if (iv16 && ir16) begin
        q16.push_back(ref16(a16, b16, bin16));
        n_acc16++;
      end
      if (ov16 && or16) begin
        if (q16.size() == 0) check("res16_unexpected", 32'(ov16), 32'd0);
        else begin
          check("res16", 32'({bo16, d16}), 32'(q16.pop_front()));
          n_res16++;
        end
      end
    end
  end

  // Drivers are called at posedge+1 and return at posedge+1 just after the accepting edge.
  task automatic send8(input logic [7:0] av, input logic [7:0] bv, input logic bi);
    int n = 0;
    bit got = 0;
    a8 = av; b8 = bv; bin8 = bi; iv8 = 1'b1;
    while (!got && n < 300) begin
      @(negedge clk);
      n++;
      if (ir8) got = 1;
    end
    if (!got) check("send8_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    iv8 = 1'b0;
  endtask

  task automatic send16(input logic [15:0] av, input logic [15:0] bv, input logic bi);
    int n = 0;
    bit got = 0;
    a16 = av; b16 = bv; bin16 = bi; iv16 = 1'b1;
    while (!got && n < 300) begin
      @(negedge clk);
      n++;
      if (ir16) got = 1;
    end
    if (!got) check("send16_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    iv16 = 1'b0;
  endtask

  task automatic wait_idle8();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ir8 && n < 300);
    if (!ir8) check("idle8_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic run8(input string nm, input logic [7:0] av, input logic [7:0] bv, input logic bi,
                      input logic [7:0] exp_d, input logic exp_b);
    send8(av, bv, bi);
    wait_idle8();
    check({nm, "_d"}, 32'(d8), 32'(exp_d));
    check({nm, "_bout"}, 32'(bo8), 32'(exp_b));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, %0d checks so far", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    iv8 = 0; or8 = 1; a8 = 0; b8 = 0; bin8 = 0;
    iv16 = 0; or16 = 1; a16 = 0; b16 = 0; bin16 = 0;
    #2;
    check("rst_in_ready", 32'(ir8), 32'd1);
    check("rst_out_valid", 32'(ov8), 32'd0);
    check("rst_d", 32'(d8), 32'd0);
    check("rst_bout", 32'(bo8), 32'd0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    // Latency and handshake timing: result W edges after accept, in_ready low for W+1 cycles.
    send8(8'h5A, 8'h33, 1'b0);
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      check($sformatf("lat_rdy_vld_%0d", j), 32'({ir8, ov8}), 32'({j == 9, j == 8}));
    end
    check("lat_d", 32'(d8), 32'h27);
    check("lat_bout", 32'(bo8), 32'd0);
    @(posedge clk); #1;

    run8("zero_minus_one", 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1);
    run8("80_minus_7f_b1", 8'h80, 8'h7F, 1'b1, 8'h00, 1'b0);
    run8("eq_bin1", 8'hC3, 8'hC3, 1'b1, 8'hFF, 1'b1);
    run8("eq_bin0", 8'hC3, 8'hC3, 1'b0, 8'h00, 1'b0);
    run8("all_zero", 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);

    // Backpressure: result held while out_ready is low, inputs ignored.
    or8 = 1'b0;
    send8(8'hA5, 8'h5A, 1'b0);
    for (int n = 0; n < 300 && !ov8; n++) @(negedge clk);
    check("bp_reach_done", 32'(ov8), 32'd1);
    @(posedge clk); #1;
    for (int k = 0; k < 5; k++) begin
      a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom); iv8 = 1'b1;
      @(negedge clk);
      check("bp_hold_vld_rdy", 32'({ov8, ir8}), 32'b10);
      check("bp_hold_d", 32'({bo8, d8}), 32'h04B);
      @(posedge clk); #1;
    end
    a8 = 8'h10; b8 = 8'h20; bin8 = 1'b0; or8 = 1'b1;
    @(negedge clk);
    check("bp_release_vld", 32'(ov8), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_idle_vld_rdy", 32'({ov8, ir8}), 32'b01);
    @(posedge clk); #1;
    iv8 = 1'b0;
    @(negedge clk);
    check("bp_accepted", 32'(ir8), 32'd0);
    @(posedge clk); #1;
    wait_idle8();
    check("bp_pending_result", 32'({bo8, d8}), 32'h1F0);

    // Reset in the middle of an operation.
    send8(8'h12, 8'h34, 1'b0);
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_rdy_vld", 32'({ir8, ov8}), 32'b10);
    check("midrst_d_bout", 32'({bo8, d8}), 32'h000);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("postrst_ready", 32'(ir8), 32'd1);
    run8("postrst_op", 8'h10, 8'h01, 1'b0, 8'h0F, 1'b0);

    // Randomised cross-check on both widths with input gaps and output stalls.
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
          send8(8'($urandom), 8'($urandom), 1'($urandom));
        end
        done8 = 1;
      end
      begin
        for (int i = 0; i < 1000; i++) begin
          repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
          send16(16'($urandom), 16'($urandom), 1'($urandom));
        end
        done16 = 1;
      end
      begin
        while (!(done8 && done16)) begin
          @(posedge clk); #1;
          or8  = ($urandom_range(0, 3) != 0);
          or16 = ($urandom_range(0, 3) != 0);
        end
        or8 = 1'b1;
        or16 = 1'b1;
      end
    join

    for (int n = 0; n < 500 && (q8.size() != 0 || q16.size() != 0); n++) @(negedge clk);
    check("count8", 32'(n_res8), 32'(n_acc8));
    check("count16", 32'(n_res16), 32'(n_acc16));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
